// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces over whole scans and reports accepted keys as {row, col} with a
// one-cycle key_valid strobe and a key_held level.
// Optional feature: define KEYPAD_REPEAT_EN to enable auto-repeat strobes.
module keypad_scanner #(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

  logic [3:0]       row_meta, row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic             tick, scan_end;

  logic [1:0]       hits, hits_next;
  logic [3:0]       scan_key, key_next;
  logic [3:0]       row_low;
  logic [2:0]       col_hits, hit_sum;
  logic [1:0]       row_idx;
  logic             scan_hit;

  state_t           state;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt, cnt_step;

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // Column slot divider; the column advances on every tick and wraps 3->0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      col <= '0;
    end else if (tick) begin
      div <= '0;
      col <= col + 2'd1;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick     = (div == DIV_LAST);
  assign scan_end = tick && (col == 2'd3);
  assign col_out  = ~(4'b0001 << col);

  // Fold the current column's sample into the running scan result.
  // The low-bit count saturates at 2: anything above one means NONE.
  always_comb begin
    row_low  = ~row_sync;
    col_hits = {2'b00, row_low[0]} + {2'b00, row_low[1]}
             + {2'b00, row_low[2]} + {2'b00, row_low[3]};
    case (row_low)
      4'b0001: row_idx = 2'd0;
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    hit_sum   = {1'b0, hits} + col_hits;
    hits_next = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    key_next  = (hits == 2'd0 && col_hits == 3'd1) ? {row_idx, col} : scan_key;
  end

  assign scan_hit = (hits_next == 2'd1);

  // Per-scan accumulator, cleared when the scan ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits     <= '0;
      scan_key <= '0;
    end else if (scan_end) begin
      hits     <= '0;
      scan_key <= '0;
    end else if (tick) begin
      hits     <= hits_next;
      scan_key <= key_next;
    end
  end

  assign cnt_step = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);
  localparam logic [RCW-1:0] REP_DELAY = RCW'(REPEAT_DELAY);
  localparam logic [RCW-1:0] REP_RATE  = RCW'(REPEAT_RATE);

  logic [RCW-1:0] rep_cnt, rep_step, rep_target;
  logic           rep_phase;

  assign rep_target = rep_phase ? REP_RATE : REP_DELAY;
  assign rep_step   = (rep_cnt == rep_target) ? rep_cnt : rep_cnt + RCW'(1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

  // Debounce/acceptance FSM, stepped once per full scan; outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        case (state)
          IDLE: begin
            if (scan_hit) begin
              cand <= key_next;
              cnt  <= CNT_ONE;
              if (DEBOUNCE_SCANS == 1) begin
                state     <= PRESSED;
                key_code  <= key_next;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (scan_hit && key_next == cand) begin
              cnt <= cnt_step;
              if (cnt_step == CNT_DONE) begin
                state     <= PRESSED;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (!scan_hit) begin
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
`endif
              if (DEBOUNCE_SCANS == 1) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end else begin
                state <= RELEASE;
                cnt   <= CNT_ONE;
              end
            end
`ifdef KEYPAD_REPEAT_EN
            else if (key_next != cand) begin
              cand      <= key_next;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
            end else if (rep_step == rep_target) begin
              key_valid <= 1'b1;
              rep_cnt   <= '0;
              rep_phase <= 1'b1;
            end else begin
              rep_cnt <= rep_step;
            end
`endif
          end
          RELEASE: begin
            if (scan_hit) begin
              state <= PRESSED;
              cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
              cand      <= key_next;
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
`endif
            end else begin
              cnt <= cnt_step;
              if (cnt_step == CNT_DONE) begin
                state    <= IDLE;
                cnt      <= '0;
                key_held <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// One column slot = 4 clks, one scan = 16 clks; after reset release scans
// end on the clock edges where the cycle count reaches a multiple of 16.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

  int cyc = 0;
  int strobes = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(3),
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .col_out(col_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // Keypad matrix: a row reads low when a pressed key sits on a driven column
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && key_valid) strobes <= strobes + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic goto(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    rst_n = 1'b0;
    keys  = k;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] col_tbl [4];
    col_tbl[0] = 4'b1110; col_tbl[1] = 4'b1101;
    col_tbl[2] = 4'b1011; col_tbl[3] = 4'b0111;
    rst_n = 1'b0;
    keys  = '0;
    repeat (2) @(negedge clk); #1;
    checks++;
    if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: col=%b code=%h valid=%b held=%b, need 1110 0 0 0",
               col_out, key_code, key_valid, key_held);
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k <= 20; k++) begin
      goto(k);
      checks++;
      if (col_out !== col_tbl[(k/4)%4]) begin
        failures++;
        $display("FAIL col_sequence cyc=%0d: col_out=%b, need %b", k, col_out, col_tbl[(k/4)%4]);
      end
      checks++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
        failures++;
        $display("FAIL idle_outputs cyc=%0d: valid=%b held=%b code=%h, need 0 0 0",
                 k, key_valid, key_held, key_code);
      end
    end
  endtask

  task automatic test_press_release;
    int s0;
    do_reset(16'h0200);   // r2c1
    s0 = strobes;
    goto(47);
    checks++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL press_early: valid=%b held=%b, need 0 0", key_valid, key_held);
    end
    goto(48);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL press_accept: valid=%b code=%h held=%b, need 1 9 1", key_valid, key_code, key_held);
    end
    goto(49);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL press_one_clk: valid=%b, need 0", key_valid);
    end
    goto(64);
    keys = '0;
    goto(111);
    checks++;
    if (key_held !== 1'b1) begin
      failures++;
      $display("FAIL release_early: held=%b, need 1", key_held);
    end
    goto(112);
    checks++;
    if (key_held !== 1'b0 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL release_done: held=%b code=%h, need 0 9", key_held, key_code);
    end
    checks++;
    if (strobes - s0 !== 1) begin
      failures++;
      $display("FAIL press_strobe_count: got %0d, need 1", strobes - s0);
    end
  endtask

  task automatic test_bounce;
    int s0;
    do_reset(16'h0080);   // r1c3
    s0 = strobes;
    for (int i = 0; i < 4; i++) begin
      goto(16*(3*i+2));
      keys = '0;
      goto(16*(3*i+3));
      keys = 16'h0080;
      checks++;
      if (key_held !== 1'b0) begin
        failures++;
        $display("FAIL bounce_held round=%0d: held=%b, need 0", i, key_held);
      end
    end
    keys = '0;
    goto(16*12 + 8);
    checks++;
    if (strobes - s0 !== 0) begin
      failures++;
      $display("FAIL bounce_strobes: got %0d, need 0", strobes - s0);
    end
  endtask

  task automatic test_multi_key;
    int s0;
    do_reset(16'h8001);   // r0c0 + r3c3
    s0 = strobes;
    goto(64);
    checks++;
    if (strobes - s0 !== 0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL multi_none: strobes=%0d held=%b, need 0 0", strobes - s0, key_held);
    end
    keys = 16'h0002;      // r0c1
    goto(111);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early: valid=%b, need 0", key_valid);
    end
    goto(112);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h1) begin
      failures++;
      $display("FAIL single_accept: valid=%b code=%h, need 1 1", key_valid, key_code);
    end
    goto(128);
    keys = 16'h0402;      // add r2c2
    goto(200);
    checks++;
    if (strobes - s0 !== 1 || key_code !== 4'h1) begin
      failures++;
      $display("FAIL add_key: strobes=%0d code=%h, need 1 1", strobes - s0, key_code);
    end
  endtask

  task automatic test_reset_mid_debounce;
    int s0;
    do_reset(16'h0200);
    s0 = strobes;
    goto(48);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL pre_accept: valid=%b code=%h, need 1 9", key_valid, key_code);
    end
    goto(64);
    keys = '0;
    goto(112);
    keys = 16'h0040;      // r1c2, two matching scans end at 128 and 144
    goto(150);
    checks++;
    if (strobes - s0 !== 1) begin
      failures++;
      $display("FAIL partial_debounce: strobes=%0d, need 1", strobes - s0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: col=%b code=%h valid=%b held=%b, need 1110 0 0 0",
               col_out, key_code, key_valid, key_held);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    s0 = strobes;
    goto(47);
    checks++;
    if (strobes - s0 !== 0) begin
      failures++;
      $display("FAIL post_reset_early: strobes=%0d, need 0", strobes - s0);
    end
    goto(48);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h6) begin
      failures++;
      $display("FAIL post_reset_accept: valid=%b code=%h, need 1 6", key_valid, key_code);
    end
  endtask

  task automatic test_back_to_back;
    do_reset(16'h0200);
    goto(64);
    keys = '0;
    goto(112);
    checks++;
    if (key_held !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release: held=%b, need 0", key_held);
    end
    keys = 16'h0008;      // r0c3
    goto(159);
    checks++;
    if (key_valid !== 1'b0 || key_code !== 4'h9) begin
      failures++;
      $display("FAIL b2b_early: valid=%b code=%h, need 0 9", key_valid, key_code);
    end
    goto(160);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h3 || key_held !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: valid=%b code=%h held=%b, need 1 3 1", key_valid, key_code, key_held);
    end
  endtask

  task automatic test_repeat;
    int s0;
    do_reset(16'h1000);   // r3c0
    s0 = strobes;
    goto(48);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hC) begin
      failures++;
      $display("FAIL repeat_accept: valid=%b code=%h, need 1 c", key_valid, key_code);
    end
`ifdef KEYPAD_REPEAT_EN
    goto(127);
    checks++;
    if (key_valid !== 1'b0) begin
      failures++;
      $display("FAIL repeat_early: valid=%b, need 0", key_valid);
    end
    goto(128);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hC) begin
      failures++;
      $display("FAIL repeat_first: valid=%b code=%h, need 1 c", key_valid, key_code);
    end
    goto(160);
    checks++;
    if (key_valid !== 1'b1) begin
      failures++;
      $display("FAIL repeat_second: valid=%b, need 1", key_valid);
    end
    goto(192);
    checks++;
    if (key_valid !== 1'b1 || key_code !== 4'hC) begin
      failures++;
      $display("FAIL repeat_third: valid=%b code=%h, need 1 c", key_valid, key_code);
    end
    goto(200);
    checks++;
    if (strobes - s0 !== 4) begin
      failures++;
      $display("FAIL repeat_count: got %0d, need 4", strobes - s0);
    end
`else
    goto(200);
    checks++;
    if (strobes - s0 !== 1 || key_code !== 4'hC || key_held !== 1'b1) begin
      failures++;
      $display("FAIL no_repeat: strobes=%0d code=%h held=%b, need 1 c 1", strobes - s0, key_code, key_held);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_multi_key();
    test_reset_mid_debounce();
    test_back_to_back();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
